softmax_classifier: RTL and testbench
=====================================

Name: softmax_classifier

Overview:
- Consumer and controller on the far end of the softmax enable/ack handshake.
- Drives the softmax layer's enable and waits for its ack. Captures the 10 IEEE-754 single-precision probabilities, then scans them sequentially for the winning class.
- Presents class index plus winning probability with a one-cycle valid pulse.
- Sits between the softmax layer and the top-level result interface.

Parameters:
- DATA_WIDTH, 32, float word width; fixed IEEE-754 single.
- NUM_CLASSES, 10, number of probabilities; index width is 4.
- TIMEOUT_CYCLES, 4096, watchdog limit; only used with the optional feature.

Ports:
- clk  input  1  system clock, posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  classification request, sampled in IDLE only.
- probs  input  DATA_WIDTH*NUM_CLASSES  softmax outputs; class i at [DATA_WIDTH*i +: DATA_WIDTH].
- soft_ack  input  1  softmax done flag.
- soft_enable  output  1  softmax enable; high only in REQ.
- busy  output  1  high in any state except IDLE.
- valid  output  1  one-cycle result strobe.
- class_idx  output  4  winning class index.
- class_prob  output  DATA_WIDTH  winning probability.
- timeout  output  1  sticky abort flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync release): state IDLE; soft_enable=0, busy=0, valid=0, class_idx=0, class_prob=0, timeout=0; capture register cleared.
- IDLE:
  - start=1 -> REQ.
  - start while busy is ignored, not queued.
- REQ:
  - soft_enable=1.
  - soft_ack=1 at edge N -> copy probs into capture register; best=elem0, best_idx=0, scan_idx=1; -> SCAN.
  - soft_enable is low from cycle N+1.
- SCAN:
  - One compare per cycle: elem[scan_idx] > best -> replace best and best_idx.
  - Elements 1..9 take 9 cycles (N+1..N+9); after scan_idx=9 -> DONE.
- DONE:
  - class_idx/class_prob updated, valid=1 for exactly one cycle (N+10); -> IDLE.
  - Result registers hold until the next DONE.
- Minimum spacing: soft_enable stays low for at least 10 cycles between requests, which guarantees the softmax clears its counters and ack. A start in the cycle valid is high is ignored; a start the following cycle is accepted.
- Compare rule (float_greater):
  - Sign-magnitude total order; +0 and -0 equal.
  - NaN (exp=0xFF, mantissa!=0) never wins and is never replaced-into.
  - Ties keep the lower index.
  - All-NaN input -> idx 0, prob = elem0.
- soft_ack already high on entry to REQ: captured on the first REQ edge (latency unchanged).
- soft_ack dropping outside REQ is ignored.
- probs changing after capture has no effect.
- rst_n asserted mid-operation: immediate return to reset values; soft_enable drops asynchronously; no valid.

Optional Feature:
- Macro SOFTMAX_CLASSIFIER_TIMEOUT_EN.
- Defined:
  - 13-bit watchdog counts REQ cycles, cleared on REQ entry.
  - Reaching TIMEOUT_CYCLES without soft_ack -> soft_enable=0, timeout=1 (sticky until next accepted start), valid pulses with class_idx=0xF, class_prob=0; -> IDLE.
- Undefined: REQ waits indefinitely; timeout tied 0; no counter logic.

Decomposition:
- Shared package cnn_pkg:
  - constants: DATA_WIDTH=32, NUM_CLASSES=10, FLOAT_ZERO, FLOAT_EXP_MAX.
  - state enum {IDLE, REQ, SCAN, DONE}.
  - typedef for the float word.
- One combinational sub-module float_greater(a, b, gt) implementing the compare rule. It is reusable by pooling layers.

Test Plan:
- Probs class3=0x3F000000 (0.5), others 0x3D4CCCCD (0.05); start -> soft_enable 1 until ack; valid exactly 10 cycles after the ack edge with idx=3, prob=0x3F000000.
- Tie: class2=class7=0x3E800000, rest 0x3DCCCCCD -> idx=2.
- Max at class0=0x3F400000, and separately max at class9 -> idx 0 / idx 9; checks scan boundaries.
- Class5=NaN 0x7FC00000, class4=0x3F000000, rest 0x3DCCCCCD -> idx=4; class8=-0.0, all others 0.0 -> idx=0.
- rst_n low two cycles after ack: soft_enable, busy, valid 0 immediately; no valid follows; next start completes normally.
- TIMEOUT_EN with TIMEOUT_CYCLES=16 and ack never asserted -> after 16 REQ cycles soft_enable=0, timeout=1, valid with idx=0xF. Without the macro, REQ persists 100+ cycles.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN types and constants: float word, state enum, NaN helper.
// Used by the softmax classifier and reusable by pooling layers.
package cnn_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef logic [DATA_WIDTH-1:0] float_t;

  localparam float_t     FLOAT_ZERO    = '0;
  localparam logic [7:0] FLOAT_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SCAN,
    DONE
  } state_t;

  function automatic logic is_nan(input float_t f);
    return (f[30:23] == FLOAT_EXP_MAX) && (f[22:0] != '0);
  endfunction

endpackage

// File: rtl/softmax_classifier_if.sv
// Softmax classifier handshake/result bundle.
// slave = classifier side, master = environment side.
interface softmax_classifier_if;
  import cnn_pkg::*;

  logic                              start;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] probs;
  logic                              soft_ack;
  logic                              soft_enable;
  logic                              busy;
  logic                              valid;
  logic [IDX_W-1:0]                  class_idx;
  float_t                            class_prob;
  logic                              timeout;

  modport master (
    output start, probs, soft_ack,
    input  soft_enable, busy, valid,
    input  class_idx, class_prob, timeout
  );

  modport slave (
    input  start, probs, soft_ack,
    output soft_enable, busy, valid,
    output class_idx, class_prob, timeout
  );

endinterface

// File: rtl/softmax_classifier_float_greater.sv
// float_greater: gt = (a > b) in sign-magnitude order, +0 == -0.
// A NaN a never wins; any ordinary a beats a NaN b.
module float_greater
  import cnn_pkg::*;
(
  input  float_t a,
  input  float_t b,
  output logic   gt
);

  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_zeros;
  logic [30:0] w_am;
  logic [30:0] w_bm;

  assign w_am    = a[30:0];
  assign w_bm    = b[30:0];
  assign w_a_nan = is_nan(a);
  assign w_b_nan = is_nan(b);
  assign w_zeros = (w_am == '0) && (w_bm == '0);

  // Prioritised compare; NaN checks dominate the ordering.
  always_comb begin
    gt = 1'b0;
    priority case (1'b1)
      w_a_nan:           gt = 1'b0;
      w_b_nan:           gt = 1'b1;
      w_zeros:           gt = 1'b0;
      (a[31] != b[31]):  gt = ~a[31];
      default:           gt = a[31] ? (w_am < w_bm) : (w_am > w_bm);
    endcase
  end

endmodule

// File: rtl/softmax_classifier.sv
// Softmax classifier: requests softmax, captures 10 floats, argmax scan.
// Optional watchdog: define SOFTMAX_CLASSIFIER_TIMEOUT_EN.
module softmax_classifier
  import cnn_pkg::*;
`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 4096
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_classifier_if.slave  s
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t           r_state;
  float_t           r_cap [NUM_CLASSES];
  float_t           r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_scan_idx;
  logic             r_soft_enable;
  logic             r_busy;
  logic             r_valid;
  logic [IDX_W-1:0] r_class_idx;
  float_t           r_class_prob;
  float_t           w_elem;
  logic             w_gt;

`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
  localparam logic [12:0] WD_LIM = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] r_wd;
  logic        r_timeout;
  assign s.timeout = r_timeout;
`else
  assign s.timeout = 1'b0;
`endif

  assign w_elem = r_cap[r_scan_idx];

  float_greater u_cmp (
    .a  (w_elem),
    .b  (r_best),
    .gt (w_gt)
  );

  // Control FSM with registered outputs and argmax datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_best        <= FLOAT_ZERO;
      r_best_idx    <= '0;
      r_scan_idx    <= '0;
      r_soft_enable <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_class_idx   <= '0;
      r_class_prob  <= FLOAT_ZERO;
      for (int i = 0; i < NUM_CLASSES; i++)
        r_cap[i] <= FLOAT_ZERO;
`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
      r_wd          <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A start during the result strobe is dropped.
          if (s.start && !r_valid) begin
            r_state       <= REQ;
            r_soft_enable <= 1'b1;
            r_busy        <= 1'b1;
`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
            r_wd          <= '0;
            r_timeout     <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (s.soft_ack) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              r_cap[i] <= s.probs[DATA_WIDTH*i +: DATA_WIDTH];
            r_best        <= s.probs[DATA_WIDTH-1:0];
            r_best_idx    <= '0;
            r_scan_idx    <= IDX_W'(1);
            r_soft_enable <= 1'b0;
            r_state       <= SCAN;
          end
`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
          else if (r_wd == WD_LIM) begin
            r_soft_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b1;
            r_valid       <= 1'b1;
            r_class_idx   <= 4'hF;
            r_class_prob  <= FLOAT_ZERO;
            r_state       <= IDLE;
          end else begin
            r_wd <= r_wd + 13'd1;
          end
`endif
        end
        SCAN: begin
          if (w_gt) begin
            r_best     <= w_elem;
            r_best_idx <= r_scan_idx;
          end
          if (r_scan_idx == LAST_IDX)
            r_state <= DONE;
          else
            r_scan_idx <= r_scan_idx + IDX_W'(1);
        end
        DONE: begin
          r_class_idx  <= r_best_idx;
          r_class_prob <= r_best;
          r_valid      <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.soft_enable = r_soft_enable;
  assign s.busy        = r_busy;
  assign s.valid       = r_valid;
  assign s.class_idx   = r_class_idx;
  assign s.class_prob  = r_class_prob;

endmodule

// File: tb/tb_softmax_classifier.sv
// Directed scoreboard bench for softmax_classifier.
// Watchdog path exercised when SOFTMAX_CLASSIFIER_TIMEOUT_EN is defined.
module tb_softmax_classifier;
  import cnn_pkg::*;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] prob;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  softmax_classifier_if sif();

`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
  softmax_classifier #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sif)
  );
`else
  softmax_classifier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sif)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] fill(input logic [31:0] v);
    logic [319:0] p;
    for (int i = 0; i < 10; i++) p[32*i +: 32] = v;
    return p;
  endfunction

  task automatic run(input string tag,
                     input logic [319:0] p,
                     input logic [3:0] ei,
                     input logic [31:0] ep,
                     input bit pre,
                     input bit early);
    exp_t e;
    int   k;
    sb.push_back('{idx: ei, prob: ep});
    sif.probs = p;
    if (!pre) begin
      if (early) sif.soft_ack = 1'b1;
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      chk({tag, "_req_en"}, 32'(sif.soft_enable), 32'd1);
      chk({tag, "_busy"}, 32'(sif.busy), 32'd1);
    end
    if (!early) begin
      tick();
      tick();
      chk({tag, "_en_hold"}, 32'(sif.soft_enable), 32'd1);
      sif.soft_ack = 1'b1;
    end
    tick();
    sif.soft_ack = 1'b0;
    sif.probs = fill(32'h3F800000);
    chk({tag, "_en_drop"}, 32'(sif.soft_enable), 32'd0);
    k = 0;
    while (!sif.valid && k < 30) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd10);
    if (sif.valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_idx"}, 32'(sif.class_idx), 32'(e.idx));
      chk({tag, "_prob"}, sif.class_prob, e.prob);
    end else begin
      chk({tag, "_result_seen"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic [319:0] p;
    int           nv;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sif.start    = 1'b0;
    sif.soft_ack = 1'b0;
    sif.probs    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(sif.soft_enable), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_valid", 32'(sif.valid), 32'd0);
    chk("rst_idx", 32'(sif.class_idx), 32'd0);
    chk("rst_prob", sif.class_prob, 32'd0);
    chk("rst_timeout", 32'(sif.timeout), 32'd0);
    rst_n = 1'b1;
    tick();

    p = fill(32'h3D4CCCCD);
    p[32*3 +: 32] = 32'h3F000000;
    run("max3", p, 4'd3, 32'h3F000000, 1'b0, 1'b0);

    sif.start = 1'b1;
    tick();
    chk("start_in_valid_busy", 32'(sif.busy), 32'd0);
    chk("start_in_valid_en", 32'(sif.soft_enable), 32'd0);
    chk("valid_one_cycle", 32'(sif.valid), 32'd0);
    tick();
    chk("start_after_valid", 32'(sif.soft_enable), 32'd1);
    sif.start = 1'b0;
    p = fill(32'h3DCCCCCD);
    p[32*2 +: 32] = 32'h3E800000;
    p[32*7 +: 32] = 32'h3E800000;
    run("tie", p, 4'd2, 32'h3E800000, 1'b1, 1'b0);
    repeat (3) tick();

    p = fill(32'h3DCCCCCD);
    p[32*0 +: 32] = 32'h3F400000;
    run("max0", p, 4'd0, 32'h3F400000, 1'b0, 1'b0);
    repeat (3) tick();

    p = fill(32'h3DCCCCCD);
    p[32*9 +: 32] = 32'h3F400000;
    run("max9", p, 4'd9, 32'h3F400000, 1'b0, 1'b1);
    repeat (3) tick();

    p = fill(32'h3DCCCCCD);
    p[32*5 +: 32] = 32'h7FC00000;
    p[32*4 +: 32] = 32'h3F000000;
    run("nan", p, 4'd4, 32'h3F000000, 1'b0, 1'b0);
    repeat (3) tick();

    p = fill(32'h00000000);
    p[32*8 +: 32] = 32'h80000000;
    run("negzero", p, 4'd0, 32'h00000000, 1'b0, 1'b0);
    repeat (3) tick();

    p = fill(32'hBF800000);
    p[32*6 +: 32] = 32'hBF000000;
    run("neg", p, 4'd6, 32'hBF000000, 1'b0, 1'b0);
    repeat (3) tick();

    sif.probs = fill(32'h3DCCCCCD);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    sif.soft_ack = 1'b1;
    tick();
    sif.soft_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(sif.soft_enable), 32'd0);
    chk("midrst_busy", 32'(sif.busy), 32'd0);
    chk("midrst_valid", 32'(sif.valid), 32'd0);
    tick();
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (sif.valid) nv++;
    end
    chk("midrst_no_valid", 32'(nv), 32'd0);
    p = fill(32'h3DCCCCCD);
    p[32*1 +: 32] = 32'h3F000000;
    run("after_rst", p, 4'd1, 32'h3F000000, 1'b0, 1'b0);
    repeat (3) tick();

`ifdef SOFTMAX_CLASSIFIER_TIMEOUT_EN
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (15) tick();
    chk("wd_en_before", 32'(sif.soft_enable), 32'd1);
    tick();
    chk("wd_en", 32'(sif.soft_enable), 32'd0);
    chk("wd_timeout", 32'(sif.timeout), 32'd1);
    chk("wd_valid", 32'(sif.valid), 32'd1);
    chk("wd_idx", 32'(sif.class_idx), 32'hF);
    chk("wd_prob", sif.class_prob, 32'd0);
    repeat (3) tick();
    chk("wd_sticky", 32'(sif.timeout), 32'd1);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("wd_clear", 32'(sif.timeout), 32'd0);
`else
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (120) tick();
    chk("req_persist_en", 32'(sif.soft_enable), 32'd1);
    chk("req_persist_busy", 32'(sif.busy), 32'd1);
    chk("req_timeout_tied", 32'(sif.timeout), 32'd0);
`endif
    p = fill(32'h3DCCCCCD);
    p[32*8 +: 32] = 32'h3F000000;
    run("late_ack", p, 4'd8, 32'h3F000000, 1'b1, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
